// File: rtl/matvec_pkg.sv
// -----------------------------------------------------------------------------
// matvec_pkg
// Shared types and sizing helpers for the matrix-vector sequencer.
//   state_t      : controller state encoding
//   DEF_ROWS/COLS: default array geometry (8x8)
//   STEPS        : number of RUN steps for the default geometry (COLS+ROWS-1)
//   DRAIN_CYCLES : cycles waited after the last MAC enable before results are
//                  read (MAC multiply register + accumulate register)
//   K_W / IDX_W  : widths of the step counter and the result index
// The helper functions let each module derive the same widths from its own
// parameter values when the geometry is overridden.
// -----------------------------------------------------------------------------
package matvec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    function automatic int steps_of(input int rows, input int cols);
        return cols + rows - 1;
    endfunction

    function automatic int k_width(input int rows, input int cols);
        return ((cols + rows) > 2) ? $clog2(cols + rows) : 1;
    endfunction

    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    localparam int DEF_ROWS     = 8;
    localparam int DEF_COLS     = 8;
    localparam int STEPS        = steps_of(DEF_ROWS, DEF_COLS);
    localparam int DRAIN_CYCLES = 2;
    localparam int K_W          = k_width(DEF_ROWS, DEF_COLS);
    localparam int IDX_W        = idx_width(DEF_ROWS);

endpackage

// File: rtl/matvec_skew_gen.sv
// -----------------------------------------------------------------------------
// matvec_skew_gen
// Combinational step decoder for the systolic MAC column.
//   k       in  : current RUN step
//   a_empty in  : per-row A FIFO empty flags
//   b_empty in  : B FIFO empty flag
//   active  out : rows taking part in step k (r <= k < r+COLS)
//   need_b  out : step k still consumes a new B element (k < COLS)
//   fire    out : every operand the step needs is available
// -----------------------------------------------------------------------------
module matvec_skew_gen
    import matvec_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int KW   = k_width(DEF_ROWS, DEF_COLS)
) (
    input  logic [KW-1:0]   k,
    input  logic [ROWS-1:0] a_empty,
    input  logic            b_empty,
    output logic [ROWS-1:0] active,
    output logic            need_b,
    output logic            fire
);

    int k_int;

    always_comb begin
        k_int  = int'(k);
        active = '0;
        // Each row starts one step after the row above it and consumes
        // COLS elements, giving the diagonal wavefront of the array.
        for (int r = 0; r < ROWS; r++) begin
            active[r] = (k_int >= r) && (k_int < r + COLS);
        end
        need_b = (k_int < COLS);
        // A row that is not active does not hold the step up, even if its
        // FIFO is empty.
        fire   = ((active & a_empty) == '0) && !(need_b && b_empty);
    end

endmodule

// File: rtl/matvec_ctrl.sv
// -----------------------------------------------------------------------------
// matvec_ctrl
// Sequencer for a column of ROWS MAC units computing C = A x B.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin one operation (only looked at in IDLE)
//   busy         : operation in progress (CLEAR..OUTPUT)
//   done         : one-cycle pulse after the last result handshake
//   a_empty      : per-row A FWFT FIFO empty flags
//   a_rd_en      : per-row A FIFO pops (data used in the same cycle)
//   b_empty      : B FWFT FIFO empty flag
//   b_rd_en      : B FIFO pop
//   mac_en       : per-row MAC enable, skewed one step per row
//   mac_clr      : clear all accumulators
//   couts        : packed accumulator outputs, row r at [r*ACC_WIDTH +: ACC_WIDTH]
//   res_valid    : result stream valid
//   res_ready    : result stream ready
//   res_data     : accumulator value of row res_idx (registered)
//   res_idx      : row index of res_data
// -----------------------------------------------------------------------------
module matvec_ctrl
    import matvec_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [ROWS-1:0]                a_empty,
    output logic [ROWS-1:0]                a_rd_en,
    input  logic                           b_empty,
    output logic                           b_rd_en,
    output logic [ROWS-1:0]                mac_en,
    output logic                           mac_clr,
    input  logic [ROWS*ACC_WIDTH-1:0]      couts,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ACC_WIDTH-1:0]           res_data,
    output logic [idx_width(ROWS)-1:0]     res_idx
);

    localparam int KW      = k_width(ROWS, COLS);
    localparam int IW      = idx_width(ROWS);
    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [KW-1:0]      K_LAST     = KW'(steps_of(ROWS, COLS) - 1);
    localparam logic [IW-1:0]      IDX_LAST   = IW'(ROWS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    // The accumulator must hold a full product; anything narrower would
    // silently truncate inside the MAC array.
    generate
        if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_width
            $error("matvec_ctrl: ACC_WIDTH must be at least 2*DATA_WIDTH");
        end
    endgenerate

    state_t               state, state_n;
    logic [KW-1:0]        k, k_n;
    logic [DRAIN_W-1:0]   drain_cnt, drain_n;
    logic [IW-1:0]        idx_n, idx_inc;
    logic [ACC_WIDTH-1:0] data_n;
    logic [ACC_WIDTH-1:0] cout_arr [ROWS];

    logic [ROWS-1:0]      active;
    logic                 need_b;
    logic                 fire;

    matvec_skew_gen #(
        .ROWS (ROWS),
        .COLS (COLS),
        .KW   (KW)
    ) u_skew (
        .k       (k),
        .a_empty (a_empty),
        .b_empty (b_empty),
        .active  (active),
        .need_b  (need_b),
        .fire    (fire)
    );

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            cout_arr[r] = couts[r*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    assign idx_inc = res_idx + 1'b1;

    // Next-state and output decode. Enables are decoded from the registered
    // state so an asynchronous reset drops them in the same cycle.
    always_comb begin
        state_n   = state;
        k_n       = k;
        drain_n   = drain_cnt;
        idx_n     = res_idx;
        data_n    = res_data;
        busy      = 1'b0;
        done      = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = '0;
        a_rd_en   = '0;
        b_rd_en   = 1'b0;
        res_valid = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                end
            end

            S_CLEAR: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
                k_n     = '0;
                state_n = S_RUN;
            end

            S_RUN: begin
                busy = 1'b1;
                // A stalled step simply repeats next cycle with k unchanged.
                if (fire) begin
                    mac_en  = active;
                    a_rd_en = active;
                    b_rd_en = need_b;
                    if (k == K_LAST) begin
                        k_n     = '0;
                        drain_n = '0;
                        state_n = S_DRAIN;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    // The last accumulate lands at the end of the previous
                    // cycle, so row 0 can be captured for the first beat.
                    idx_n   = '0;
                    data_n  = cout_arr[0];
                    state_n = S_OUTPUT;
                end else begin
                    drain_n = drain_cnt + 1'b1;
                end
            end

            S_OUTPUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    if (res_idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        idx_n  = idx_inc;
                        data_n = cout_arr[idx_inc];
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            drain_cnt <= '0;
            res_idx   <= '0;
            res_data  <= '0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            drain_cnt <= drain_n;
            res_idx   <= idx_n;
            res_data  <= data_n;
        end
    end

endmodule

// File: tb/tb_matvec_ctrl.sv
`timescale 1ns/1ps
module tb_matvec_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int IW   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [ROWS-1:0]      a_empty;
    logic [ROWS-1:0]      a_rd_en;
    logic                 b_empty;
    logic                 b_rd_en;
    logic [ROWS-1:0]      mac_en;
    logic                 mac_clr;
    logic [ROWS*AW-1:0]   couts;
    logic                 res_valid;
    logic                 res_ready = 1'b1;
    logic [AW-1:0]        res_data;
    logic [IW-1:0]        res_idx;

    logic [ROWS-1:0]      a_force = '0;
    logic                 fill_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matvec_ctrl #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .a_empty   (a_empty),
        .a_rd_en   (a_rd_en),
        .b_empty   (b_empty),
        .b_rd_en   (b_rd_en),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .couts     (couts),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx)
    );

    // ---------------- FWFT FIFO and MAC array models ----------------
    logic [DW-1:0]   a_mem [ROWS][COLS];
    logic [DW-1:0]   b_mem [COLS];
    int              a_ptr [ROWS];
    int              b_ptr;
    logic [DW-1:0]   a_head [ROWS];
    logic [DW-1:0]   b_head;
    logic [DW-1:0]   b_in  [ROWS];
    logic [DW-1:0]   bsh   [ROWS];
    logic [2*DW-1:0] prod  [ROWS];
    logic [ROWS-1:0] pv = '0;
    logic [AW-1:0]   acc   [ROWS];

    always_comb begin
        a_empty = '0;
        couts   = '0;
        b_empty = (b_ptr >= COLS);
        b_head  = (b_ptr < COLS) ? b_mem[b_ptr] : '0;
        for (int r = 0; r < ROWS; r++) begin
            a_empty[r] = (a_ptr[r] >= COLS) || a_force[r];
            a_head[r]  = (a_ptr[r] < COLS) ? a_mem[r][a_ptr[r]] : '0;
            b_in[r]    = (r == 0) ? b_head : bsh[(r > 0) ? r - 1 : 0];
            couts[r*AW +: AW] = acc[r];
        end
    end

    // B travels down the column one row per firing step.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int r = 0; r < ROWS; r++) a_ptr[r] <= 0;
            b_ptr <= 0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                if (a_rd_en[r] && a_ptr[r] < COLS) a_ptr[r] <= a_ptr[r] + 1;
            if (b_rd_en && b_ptr < COLS) b_ptr <= b_ptr + 1;
        end
        if (|mac_en)
            for (int r = 0; r < ROWS; r++) bsh[r] <= b_in[r];
        for (int r = 0; r < ROWS; r++) begin
            pv[r] <= mac_en[r];
            if (mac_en[r]) prod[r] <= a_head[r] * b_in[r];
            if (mac_clr)    acc[r] <= '0;
            else if (pv[r]) acc[r] <= acc[r] + AW'(prod[r]);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // mode 0: identity A, B = 1..COLS; mode 1: A and B all 255
    task automatic load(input int mode);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                a_mem[r][c] = (mode == 1) ? 8'd255 : ((r == c) ? 8'd1 : 8'd0);
        for (int c = 0; c < COLS; c++)
            b_mem[c] = (mode == 1) ? 8'd255 : DW'(c + 1);
        @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    typedef struct {
        string name;
        int    mode;
        int    stall_t;    // first cycle a_empty[3] is forced high
        int    stall_len;
        int    hold_t;     // first cycle res_ready is low
        int    hold_len;
        int    x0, x1, x2; // cycles with a stray start pulse (0 = none)
        int    exp_done;   // cycle of the done pulse, start accepted at cycle 0
        int    exp_base;   // expected result of row r = exp_base + r*exp_step
        int    exp_step;
    } vec_t;

    vec_t vecs [5];

    task automatic run_op(input vec_t v, input string tag);
        int  t, done_t;
        bit  prof_ok, stall_ok, hold_ok;
        int  got [ROWS];
        int  cnt [ROWS];
        int  pops;
        for (int r = 0; r < ROWS; r++) begin got[r] = 0; cnt[r] = 0; end
        done_t = -1; prof_ok = 1; stall_ok = 1; hold_ok = 1;
        @(negedge clk);
        start = 1'b1; res_ready = 1'b1; a_force = '0; t = 0;
        while (done_t < 0 && t < 200) begin
            @(negedge clk);
            t++;
            start     = (t == v.x0) || (t == v.x1) || (t == v.x2);
            res_ready = !(v.hold_len > 0 && t >= v.hold_t && t < v.hold_t + v.hold_len);
            a_force   = (v.stall_len > 0 && t >= v.stall_t && t < v.stall_t + v.stall_len) ? 8'h08 : 8'h00;
            #1;
            if (busy !== (t >= 1 && t < v.exp_done)) prof_ok = 0;
            if (done !== (t == v.exp_done))          prof_ok = 0;
            if (mac_clr !== (t == 1))                prof_ok = 0;
            if (a_force != 0 && (mac_en !== '0 || a_rd_en !== '0 || b_rd_en !== 1'b0)) stall_ok = 0;
            if (!res_ready && !(res_valid === 1'b1 && res_idx === 3'd2 &&
                                res_data === AW'(v.exp_base + 2 * v.exp_step))) hold_ok = 0;
            if (res_valid === 1'b1 && res_ready) begin
                cnt[res_idx]++;
                got[res_idx] = int'(res_data);
            end
            if (done === 1'b1) done_t = t;
        end
        check({tag, "_done_cycle"}, done_t, v.exp_done);
        check({tag, "_busy_done_clr_profile"}, prof_ok, 1);
        if (v.stall_len > 0) check({tag, "_stall_no_enables"}, stall_ok, 1);
        if (v.hold_len > 0)  check({tag, "_ready_low_hold"}, hold_ok, 1);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("%s_res%0d_value", tag, r), got[r], v.exp_base + r * v.exp_step);
            check($sformatf("%s_res%0d_count", tag, r), cnt[r], 1);
        end
        pops = b_ptr;
        for (int r = 0; r < ROWS; r++) pops += a_ptr[r];
        check({tag, "_total_pops"}, pops, (ROWS + 1) * COLS);
        // One cycle after done: back in IDLE, stray start in DONE not taken.
        @(negedge clk);
        start = 1'b0; res_ready = 1'b1; a_force = '0;
        #1;
        check({tag, "_idle_after_done"}, {busy, done, res_valid}, 3'b000);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{"identity", 0, 0, 0, 0, 0, 0, 0, 0, 27, 1, 1};
        vecs[1] = '{"all255",   1, 0, 0, 0, 0, 0, 0, 0, 27, 520200, 0};
        vecs[2] = '{"stall",    0, 6, 5, 0, 0, 0, 0, 0, 32, 1, 1};
        vecs[3] = '{"hold",     0, 0, 0, 21, 4, 0, 0, 0, 31, 1, 1};
        vecs[4] = '{"restart",  0, 0, 0, 0, 0, 5, 22, 27, 27, 1, 1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl_outputs", {busy, done, a_rd_en, b_rd_en, mac_en, mac_clr, res_valid}, '0);
        check("reset_res_data", res_data, 0);
        check("reset_res_idx", res_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].mode);
            run_op(vecs[i], vecs[i].name);
        end

        // Abort with reset in the middle of RUN (step k=5 at cycle 7).
        load(0);
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("abort_mac_en_at_k5", mac_en, 8'h3F);
        rst_n = 1'b0;
        #1;
        check("abort_ctrl_outputs", {busy, done, a_rd_en, b_rd_en, mac_en, mac_clr, res_valid}, '0);
        check("abort_res_data_idx", {res_data, res_idx}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("abort_idle", {busy, res_valid, done}, 3'b000);
        load(0);
        run_op(vecs[0], "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matvec_ctrl.md
Name: matvec_ctrl

Overview:
Sequencer for a column of ROWS MAC units that computes C = A x B, with A a ROWS x COLS 8-bit matrix and B a COLS-entry 8-bit vector.
- Pops A row elements from ROWS first-word-fall-through (FWFT) FIFOs and B elements from one FWFT FIFO.
- Drives a per-row skewed MAC enable and a common clear.
- Waits out the MAC pipeline latency, then streams the ROWS accumulator results out over a valid/ready port.
- Sits between the operand buffers and the MAC array in the matrix-multiply datapath.

Parameters:
ROWS, 8, number of MAC units (rows of A)
COLS, 8, vector length (columns of A, entries of B)
DATA_WIDTH, 8, operand width
ACC_WIDTH, 24, MAC accumulator width (3*DATA_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin one matrix-vector operation; sampled in IDLE only
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last result handshake
a_empty  in  ROWS  A FIFO empty flags, one per row
a_rd_en  out  ROWS  A FIFO pop, one per row; data is valid in the same cycle
b_empty  in  1  B FIFO empty flag
b_rd_en  out  1  B FIFO pop
mac_en  out  ROWS  per-row MAC enable
mac_clr  out  1  clear all MAC accumulators
couts  in  ROWS*ACC_WIDTH  MAC accumulator outputs; row r occupies bits [r*ACC_WIDTH +: ACC_WIDTH]
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  ACC_WIDTH  accumulator value of row res_idx
res_idx  out  $clog2(ROWS)  row index of res_data

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, a_rd_en, b_rd_en, mac_en, mac_clr and res_valid are 0; res_data and res_idx are 0.
- States: IDLE, CLEAR, RUN, DRAIN, OUTPUT, DONE.
- IDLE: start=1 -> CLEAR. busy, done and all enables stay 0.
- CLEAR: mac_clr=1 for exactly 1 cycle; step counter k is cleared to 0; -> RUN.
- RUN:
  - Step counter k runs 0 .. COLS+ROWS-2. Counter width is $clog2(COLS+ROWS).
  - Row r is active when r <= k < r+COLS (systolic skew of one cycle per row).
  - b needed when k < COLS.
  - Step fires when every active row has a_empty[r]=0 and, if b is needed, b_empty=0.
  - On a firing step: mac_en[r]=a_rd_en[r]=1 for each active row; b_rd_en=1 if b is needed; k increments.
  - On a non-firing step (stall): all mac_en, a_rd_en and b_rd_en are 0 and k holds. A stall costs exactly one cycle per stalled step.
  - After the firing step with k=COLS+ROWS-2 -> DRAIN.
- DRAIN: exactly 2 cycles with all enables low, covering the MAC multiply register plus the accumulate stage; -> OUTPUT with res_idx=0.
- OUTPUT:
  - res_valid=1; res_data = couts slice selected by res_idx, registered (presented the cycle res_idx changes).
  - Handshake on res_valid && res_ready: res_idx increments.
  - Handshake with res_idx=ROWS-1 -> DONE.
  - If res_ready=0, res_valid, res_data and res_idx hold.
- DONE: done=1 for 1 cycle, busy=0; -> IDLE.
- busy=1 in CLEAR, RUN, DRAIN and OUTPUT.
- start while not in IDLE is ignored; it is not queued.
- Accumulator overflow wraps modulo 2^ACC_WIDTH inside the MAC. The controller does not check for it.
- Asserting rst_n low at any point aborts the operation immediately to reset values; FIFO contents are not touched.
- No-stall latency, 8x8, start accepted at cycle 0:
  - CLEAR at cycle 1.
  - RUN at cycles 2-16 (15 steps).
  - DRAIN at cycles 17-18.
  - First res_valid at cycle 19.
  - With res_ready held at 1, done at cycle 27.

Decomposition:
- Package matvec_pkg holds:
  - the state enum type;
  - localparams STEPS=COLS+ROWS-1 and DRAIN_CYCLES=2;
  - the widths of k and res_idx.
- One sub-module, matvec_skew_gen: combinational active-row mask, need_b and fire from k, a_empty and b_empty.
- FSM, counters and the result mux stay in matvec_ctrl.

Test Plan:
- Identity A, B=1..8, FIFOs prefilled, res_ready=1, bench MAC models attached -> results 1,2,...,8 on res_idx 0..7; done exactly 27 cycles after start; busy high for cycles 1-26.
- A all 255, B all 255 -> every result 520200 (0x07F008); no wrap.
- Same as identity test with a_empty[3] forced high for 5 cycles mid-RUN -> no pops and mac_en=0 during the stall; results unchanged; done delayed by exactly 5 cycles.
- res_ready low for 4 cycles at res_idx=2 -> res_valid, res_idx=2 and res_data held; each result is delivered exactly once.
- start pulsed again during RUN and OUTPUT -> ignored; exactly one done pulse; next start accepted only after returning to IDLE.
- rst_n asserted at RUN step k=5 -> all outputs 0 within the same cycle (asynchronous); state IDLE; a fresh start runs to completion with correct results after the FIFOs are refilled.
